gaplus_sprite_scanner: RTL

- Reader-side counterpart of the shared sprite attribute RAM. Once per scanline, walks all 64 sprite entries through the 128-word sprite-attribute read port.
- Tests each entry for vertical coincidence with the upcoming line. Pushes hit records into a small output FIFO consumed by the sprite line renderer.
- Sits in the video clock domain between the shared-memory sprite port and the sprite line buffer.

---
 rtl/gaplus_sprite_scanner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gaplus_sprite_scanner.sv
// Per-scanline sprite attribute walker: scans 64 entries for vertical hits on
// the upcoming line and queues hit records for the sprite line renderer.
module gaplus_sprite_scanner #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_HITS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hstart,
    input  logic [8:0]  vpos,
    output logic [6:0]  spra_a,
    input  logic [23:0] spra_d,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [37:0] hit_data,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  hit_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [4:0]    HIT_MAX  = 5'(MAX_HITS);

    typedef enum logic [2:0] {IDLE, RD1, EV1, RD0, EV0, PUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    n_q, n_d;
    logic [8:0]    vpos_q, vpos_d;
    logic [8:0]    x_q, x_d;
    logic [4:0]    row_q, row_d;
    logic [23:0]   w0_q, w0_d;
    logic [6:0]    spra_a_q, spra_a_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [4:0]    hcnt_q, hcnt_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hv_q, hv_d;
    logic [37:0]   mem_q [FIFO_DEPTH];

    logic       push, pop, flush, step, full, hit;
    logic [8:0] dy;

    assign pop  = hv_q && hit_ready;
    assign full = (cnt_q == FULL_CNT);
    // Row offset into the sprite; the 9-bit wrap lets sprites straddle line 511/0.
    assign dy   = vpos_q - {spra_d[17], spra_d[7:0]};
    assign hit  = !spra_d[23] && (dy < (spra_d[18] ? 9'd32 : 9'd16));

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        vpos_d   = vpos_q;
        x_d      = x_q;
        row_d    = row_q;
        w0_d     = w0_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        hcnt_d   = hcnt_q;
        spra_a_d = spra_a_q;
        push     = 1'b0;
        flush    = 1'b0;
        step     = 1'b0;
        case (state_q)
            RD1: state_d = EV1;
            EV1: begin
                if (hit) begin
                    x_d     = {spra_d[16], spra_d[15:8]};
                    row_d   = dy[4:0];
                    state_d = RD0;
                end else begin
                    step = 1'b1;
                end
            end
            RD0: state_d = EV0;
            EV0: begin
                w0_d = spra_d;
                if (hcnt_q == HIT_MAX) begin
                    ovf_d = 1'b1;
                    step  = 1'b1;
                end else begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                // A same-cycle pop frees the slot, so a full FIFO need not stall.
                if (!full || pop) begin
                    push   = 1'b1;
                    hcnt_d = hcnt_q + 5'd1;
                    step   = 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: ;
        endcase
        if (step) begin
            if (n_q == 6'd63) begin
                state_d = DONE;
            end else begin
                n_d     = n_q + 6'd1;
                state_d = RD1;
            end
        end
        if (hstart) begin
            vpos_d  = vpos;
            n_d     = 6'd0;
            flush   = 1'b1;
            push    = 1'b0;
            ovf_d   = 1'b0;
            hcnt_d  = 5'd0;
            busy_d  = 1'b1;
            state_d = RD1;
        end
        // Address is registered on entry so data lands in the following EV state.
        if (state_d == RD1)      spra_a_d = {n_d, 1'b1};
        else if (state_d == RD0) spra_a_d = {n_d, 1'b0};
    end

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        hv_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            vpos_q   <= '0;
            x_q      <= '0;
            row_q    <= '0;
            w0_q     <= '0;
            spra_a_q <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hcnt_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            hv_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            vpos_q   <= vpos_d;
            x_q      <= x_d;
            row_q    <= row_d;
            w0_q     <= w0_d;
            spra_a_q <= spra_a_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            hcnt_q   <= hcnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            hv_q     <= hv_d;
            if (push) mem_q[wr_q] <= {w0_q, x_q, row_q};
        end
    end

    assign spra_a    = spra_a_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign hit_count = hcnt_q;
    assign hit_valid = hv_q;
    assign hit_data  = mem_q[rd_q];

endmodule
